// File: rtl/n_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned SUB_DEFAULT_WIDTH = 32;

endpackage : sub_pkg

// File: rtl/n_bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - b_in with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule : full_subtractor

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module n_bit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned N = SUB_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // a_q doubles as the result register: difference bits enter at the MSB
  // while minuend bits leave at the LSB, so after N shifts it holds a - b.
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            bor_q, bor_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            borrow_out_q, borrow_out_d;
  logic            busy_q, done_q;
  logic            d_s, bout_s;

`ifdef SUB_OVERFLOW_EN
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .x     (a_q[0]),
    .y     (b_q[0]),
    .b_in  (bor_q),
    .d     (d_s),
    .b_out (bout_s)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    bor_d        = bor_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = {CW{1'b0}};
          a_d     = a;
          b_d     = b;
          bor_d   = 1'b0;
`ifdef SUB_OVERFLOW_EN
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = {d_s, a_q[N-1:1]};
        b_d   = {1'b0, b_q[N-1:1]};
        bor_d = bout_s;
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          cnt_d        = {CW{1'b0}};
          diff_d       = {d_s, a_q[N-1:1]};
          borrow_out_d = bout_s;
`ifdef SUB_OVERFLOW_EN
          ovf_d        = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_s);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CW{1'b0}};
      a_q          <= {N{1'b0}};
      b_q          <= {N{1'b0}};
      bor_q        <= 1'b0;
      diff_q       <= {N{1'b0}};
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      bor_q        <= bor_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= (state_d == SHIFT);
      done_q       <= (state_d == DONE);
`ifdef SUB_OVERFLOW_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule : n_bit_serial_subtractor

// File: tb/tb_n_bit_serial_subtractor.sv
// Scoreboard bench for n_bit_serial_subtractor at N=8 with directed vectors.
module tb_n_bit_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct {
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   done_count = 0;
  int   n_pass     = 0;
  int   n_total    = 0;

  n_bit_serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow_out", 32'(borrow_out), 32'(e.bo));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SUB_OVERFLOW_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Single-cycle start pulse; called just after a rising edge.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] dv, input logic bov, input logic ovv,
                       input bit expect_done);
    exp_t e;
    e.d = dv; e.bo = bov; e.ov = ovv; e.cyc = cyc + N + 1;
    if (expect_done) sb.push_back(e);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int c0;
    int dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic vectors
    issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b1);
    drain(40);
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    drain(40);
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    drain(40);
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 32'd0);

    // Start during SHIFT is ignored
    dc = done_count;
    issue(8'h10, 8'h03, 8'h0D, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("busy_shift", 32'(busy), 32'd1);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(40);
    repeat (12) @(posedge clk);
    #1;
    check("one_done", 32'(done_count - dc), 32'd1);
    check("held_diff", 32'(diff), 32'h0D);

    // Reset in SHIFT cycle 4 aborts
    issue(8'h5A, 8'h23, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    dc = done_count;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    issue(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    drain(40);

    // Back-to-back with start held across done
    @(posedge clk); #1;
    c0 = cyc;
    sb.push_back('{d: 8'h0F, bo: 1'b0, ov: 1'b0, cyc: c0 + 9});
    sb.push_back('{d: 8'hFF, bo: 1'b1, ov: 1'b0, cyc: c0 + 18});
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02;
    while (cyc < c0 + 10) @(posedge clk);
    #1;
    start = 1'b0;
    drain(40);
    repeat (3) @(posedge clk);
    #1;
    check("final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_n_bit_serial_subtractor
